// File: rtl/bus_resp_pkg.sv
// Shared definitions for the bus response block: FSM encoding, parameter
// defaults, bus widths, latched-request payload and error read data.
package bus_resp_pkg;

  localparam int unsigned NMOD_DEF    = 14;
  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned MOD_W       = 8;
  localparam int unsigned MAX_MOD     = 16;
  localparam int unsigned WDOG_W      = 8;

  // Read data returned on a failed access
  localparam logic [DATA_W-1:0] ERR_RDATA = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Access attributes captured when a request is accepted
  typedef struct packed {
    logic              we;
    logic [MOD_W-1:0]  mod;
    logic [ADDR_W-1:0] addr;
  } req_t;

endpackage

// File: rtl/bus_resp_if.sv
// CPU/slave-side bus bundle for bus_resp.
// slave  : view of the responder (bus_resp itself).
// master : view of the CPU / decoder environment driving it.
interface bus_resp_if;
  import bus_resp_pkg::*;

  logic                        req;
  logic                        we;
  logic [MOD_W-1:0]            mod;
  logic [ADDR_W-1:0]           eff_addr;
  logic [MAX_MOD-1:0]          mod_rdy;
  logic [MAX_MOD*DATA_W-1:0]   mod_data;
  logic                        clr_err;
  logic [DATA_W-1:0]           cpu_data;
  logic                        ack;
  logic                        stall;
  logic                        bus_err;
  logic                        err_flag;
  logic [ADDR_W-1:0]           err_addr;

  modport slave (
    input  req, we, mod, eff_addr, mod_rdy, mod_data, clr_err,
    output cpu_data, ack, stall, bus_err, err_flag, err_addr
  );

  modport master (
    output req, we, mod, eff_addr, mod_rdy, mod_data, clr_err,
    input  cpu_data, ack, stall, bus_err, err_flag, err_addr
  );

endinterface

// File: rtl/bus_wdog.sv
// Wait-cycle counter with terminal-count flag.
// clk/rst  : clock, async active-high reset
// clr_i    : synchronous clear to zero (priority over en_i)
// en_i     : count enable
// tc_val_i : terminal count value
// tc_o     : high while the count equals tc_val_i
module bus_wdog
  import bus_resp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WDOG_W-1:0] tc_val_i,
  output logic              tc_o
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/bus_resp.sv
// Bus response controller: accepts a CPU access, waits for the decoded
// slave's ready (bounded by TIMEOUT), returns read data and a one-cycle ack,
// or a bus error with sticky error status and failing address.
// clk/rst : clock, async active-high reset
// bus     : bus_resp_if.slave (req/we/mod/eff_addr/mod_rdy/mod_data/clr_err in;
//           cpu_data/ack/stall/bus_err/err_flag/err_addr out)
module bus_resp
  import bus_resp_pkg::*;
#(
  parameter int unsigned NMOD    = NMOD_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  bus_resp_if.slave   bus
);

  state_e             state_q, state_d;
  req_t               req_q, req_d, req_live, req_sel;
  logic [DATA_W-1:0]  cpu_data_q, cpu_data_d, rdata_sel;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic               ack_q, ack_d, bus_err_q, bus_err_d, err_flag_q, err_flag_d;
  logic [3:0]         mod_idx;
  logic               mod_ok, rdy_sel;
  logic               wd_clr, wd_en, wd_tc;
  logic               do_resp, do_err;

  // In IDLE the live request is being latched this edge; afterwards only
  // the latched copy steers ready/data selection.
  assign req_live  = {bus.we, bus.mod, bus.eff_addr};
  assign req_sel   = (state_q == ST_IDLE) ? req_live : req_q;
  assign mod_idx   = req_sel.mod[3:0];
  assign mod_ok    = 32'(req_sel.mod) < NMOD;
  assign rdy_sel   = mod_ok & bus.mod_rdy[mod_idx];
  assign rdata_sel = bus.mod_data[{mod_idx, 5'd0} +: DATA_W];

  bus_wdog u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .tc_val_i (8'(TIMEOUT - 1)),
    .tc_o     (wd_tc)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cpu_data_d = cpu_data_q;
    err_addr_d = err_addr_q;
    ack_d      = 1'b0;
    bus_err_d  = 1'b0;
    err_flag_d = err_flag_q & ~bus.clr_err;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;
    do_resp    = 1'b0;
    do_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        wd_clr = 1'b1;
        if (bus.req) begin
          req_d = req_live;
          if (!mod_ok)      do_err  = 1'b1;
          else if (rdy_sel) do_resp = 1'b1;
          else              state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ready takes precedence over an expiring timeout
        if (rdy_sel)    do_resp = 1'b1;
        else if (wd_tc) do_err  = 1'b1;
        else            wd_en   = 1'b1;
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (do_resp) begin
      state_d = ST_RESP;
      ack_d   = 1'b1;
      if (!req_sel.we) cpu_data_d = rdata_sel;
    end
    if (do_err) begin
      state_d    = ST_ERR;
      ack_d      = 1'b1;
      bus_err_d  = 1'b1;
      err_flag_d = 1'b1;
      err_addr_d = req_sel.addr;
      if (!req_sel.we) cpu_data_d = ERR_RDATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      cpu_data_q <= '0;
      err_addr_q <= '0;
      ack_q      <= 1'b0;
      bus_err_q  <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cpu_data_q <= cpu_data_d;
      err_addr_q <= err_addr_d;
      ack_q      <= ack_d;
      bus_err_q  <= bus_err_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus.cpu_data = cpu_data_q;
  assign bus.ack      = ack_q;
  assign bus.bus_err  = bus_err_q;
  assign bus.err_flag = err_flag_q;
  assign bus.err_addr = err_addr_q;
  // CPU hold is the only combinational output; forced low during reset
  assign bus.stall    = ~rst & (((state_q == ST_IDLE) & bus.req) | (state_q == ST_WAIT));

endmodule

// File: tb/tb_bus_resp.sv
// Directed self-checking bench for bus_resp (TIMEOUT=4, NMOD=14).
module tb_bus_resp;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  bus_resp_if bus ();

  bus_resp #(.NMOD(14), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 1'b1;
    #2;
    n_cmp++; if (bus.stall !== 1'b0)        begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.ack !== 1'b0)          begin n_bad++; $display("FAIL rst_ack: got %b want 0", bus.ack); end
    n_cmp++; if (bus.bus_err !== 1'b0)      begin n_bad++; $display("FAIL rst_bus_err: got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.cpu_data !== 32'h0)    begin n_bad++; $display("FAIL rst_cpu_data: got %h want 0", bus.cpu_data); end
    n_cmp++; if (bus.err_flag !== 1'b0)     begin n_bad++; $display("FAIL rst_err_flag: got %b want 0", bus.err_flag); end
    n_cmp++; if (bus.err_addr !== 32'h0)    begin n_bad++; $display("FAIL rst_err_addr: got %h want 0", bus.err_addr); end
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b0)        begin n_bad++; $display("FAIL rst_stall_held: got %b want 0", bus.stall); end
    bus.req = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0)          begin n_bad++; $display("FAIL post_rst_ack: got %b want 0", bus.ack); end
  endtask

  task automatic test_read_ready();
    cyc();
    bus.mod_rdy = 16'h0004; bus.mod = 8'd2; bus.we = 1'b0; bus.eff_addr = 32'h100; bus.req = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1)        begin n_bad++; $display("FAIL rr_stall_T: got %b want 1", bus.stall); end
    n_cmp++; if (bus.ack !== 1'b0)          begin n_bad++; $display("FAIL rr_ack_T: got %b want 0", bus.ack); end
    cyc();
    bus.req = 1'b0; bus.mod = 8'd0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1)          begin n_bad++; $display("FAIL rr_ack_T1: got %b want 1", bus.ack); end
    n_cmp++; if (bus.cpu_data !== 32'h12345678) begin n_bad++; $display("FAIL rr_data: got %h want 12345678", bus.cpu_data); end
    n_cmp++; if (bus.bus_err !== 1'b0)      begin n_bad++; $display("FAIL rr_bus_err: got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.stall !== 1'b0)        begin n_bad++; $display("FAIL rr_stall_T1: got %b want 0", bus.stall); end
    cyc();
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0)          begin n_bad++; $display("FAIL rr_ack_T2: got %b want 0", bus.ack); end
  endtask

  task automatic test_read_wait();
    int stalls, acks, ack_at;
    stalls = 0; acks = 0; ack_at = -1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) begin
        bus.mod_rdy = 16'h0004; bus.mod = 8'd1; bus.we = 1'b0; bus.eff_addr = 32'h200; bus.req = 1'b1;
      end
      // Redirect decoder to a ready slave; the accepted access must not follow
      if (i == 1) begin bus.mod = 8'd2; bus.eff_addr = 32'hFFF; end
      if (i == 3) bus.mod_rdy = 16'h0006;
      if (acks > 0) bus.req = 1'b0;
      @(negedge clk);
      if (bus.stall === 1'b1) stalls++;
      if (bus.ack === 1'b1) begin acks++; if (ack_at < 0) ack_at = i; end
    end
    n_cmp++; if (ack_at !== 4)              begin n_bad++; $display("FAIL rw_ack_cycle: got %0d want 4", ack_at); end
    n_cmp++; if (acks !== 1)                begin n_bad++; $display("FAIL rw_ack_count: got %0d want 1", acks); end
    n_cmp++; if (stalls !== 4)              begin n_bad++; $display("FAIL rw_stall_count: got %0d want 4", stalls); end
    n_cmp++; if (bus.cpu_data !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rw_data: got %h want cafef00d", bus.cpu_data); end
  endtask

  task automatic test_timeout();
    int stalls, acks, errs, ack_at, err_at;
    stalls = 0; acks = 0; errs = 0; ack_at = -1; err_at = -1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (i == 0) begin
        bus.mod_rdy = 16'h0004; bus.mod = 8'd5; bus.we = 1'b0; bus.eff_addr = 32'h10; bus.req = 1'b1;
      end
      if (i == 1) begin bus.mod = 8'd2; bus.eff_addr = 32'hBAD0; end
      if (acks > 0) bus.req = 1'b0;
      @(negedge clk);
      if (bus.stall === 1'b1) stalls++;
      if (bus.ack === 1'b1) begin acks++; if (ack_at < 0) ack_at = i; end
      if (bus.bus_err === 1'b1) begin errs++; if (err_at < 0) err_at = i; end
    end
    n_cmp++; if (ack_at !== 5)              begin n_bad++; $display("FAIL to_ack_cycle: got %0d want 5", ack_at); end
    n_cmp++; if (err_at !== 5)              begin n_bad++; $display("FAIL to_err_cycle: got %0d want 5", err_at); end
    n_cmp++; if (acks !== 1)                begin n_bad++; $display("FAIL to_ack_count: got %0d want 1", acks); end
    n_cmp++; if (errs !== 1)                begin n_bad++; $display("FAIL to_err_count: got %0d want 1", errs); end
    n_cmp++; if (stalls !== 5)              begin n_bad++; $display("FAIL to_stall_count: got %0d want 5", stalls); end
    n_cmp++; if (bus.cpu_data !== 32'h0)    begin n_bad++; $display("FAIL to_data: got %h want 0", bus.cpu_data); end
    n_cmp++; if (bus.err_flag !== 1'b1)     begin n_bad++; $display("FAIL to_err_flag: got %b want 1", bus.err_flag); end
    n_cmp++; if (bus.err_addr !== 32'h10)   begin n_bad++; $display("FAIL to_err_addr: got %h want 10", bus.err_addr); end
    cyc();
    bus.clr_err = 1'b1;
    cyc();
    bus.clr_err = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.err_flag !== 1'b0)     begin n_bad++; $display("FAIL clr_err_flag: got %b want 0", bus.err_flag); end
    n_cmp++; if (bus.err_addr !== 32'h10)   begin n_bad++; $display("FAIL clr_err_addr: got %h want 10", bus.err_addr); end
  endtask

  task automatic test_bad_mod();
    cyc();
    bus.mod = 8'hF0; bus.eff_addr = 32'h20; bus.we = 1'b0; bus.req = 1'b1;
    bus.clr_err = 1'b1;   // collides with the error set on the same edge
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1)        begin n_bad++; $display("FAIL bm_stall_T: got %b want 1", bus.stall); end
    cyc();
    bus.req = 1'b0; bus.clr_err = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1)          begin n_bad++; $display("FAIL bm_ack: got %b want 1", bus.ack); end
    n_cmp++; if (bus.bus_err !== 1'b1)      begin n_bad++; $display("FAIL bm_bus_err: got %b want 1", bus.bus_err); end
    n_cmp++; if (bus.err_flag !== 1'b1)     begin n_bad++; $display("FAIL bm_err_flag: got %b want 1", bus.err_flag); end
    n_cmp++; if (bus.err_addr !== 32'h20)   begin n_bad++; $display("FAIL bm_err_addr: got %h want 20", bus.err_addr); end
    n_cmp++; if (bus.stall !== 1'b0)        begin n_bad++; $display("FAIL bm_stall_T1: got %b want 0", bus.stall); end
    cyc();
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b0)          begin n_bad++; $display("FAIL bm_ack_T2: got %b want 0", bus.ack); end
    n_cmp++; if (bus.bus_err !== 1'b0)      begin n_bad++; $display("FAIL bm_bus_err_T2: got %b want 0", bus.bus_err); end
    n_cmp++; if (bus.err_flag !== 1'b1)     begin n_bad++; $display("FAIL bm_err_sticky: got %b want 1", bus.err_flag); end
  endtask

  task automatic test_write();
    cyc();
    bus.mod_rdy = 16'h0008; bus.mod = 8'd3; bus.we = 1'b0; bus.eff_addr = 32'h30; bus.req = 1'b1;
    cyc();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.cpu_data !== 32'hAAAA5555) begin n_bad++; $display("FAIL wr_preload: got %h want aaaa5555", bus.cpu_data); end
    cyc();
    bus.mod_rdy = 16'h0010; bus.mod = 8'd4; bus.we = 1'b1; bus.eff_addr = 32'h40; bus.req = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1)        begin n_bad++; $display("FAIL wr_stall: got %b want 1", bus.stall); end
    cyc();
    bus.req = 1'b0; bus.we = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1)          begin n_bad++; $display("FAIL wr_ack: got %b want 1", bus.ack); end
    n_cmp++; if (bus.cpu_data !== 32'hAAAA5555) begin n_bad++; $display("FAIL wr_data_kept: got %h want aaaa5555", bus.cpu_data); end
    n_cmp++; if (bus.bus_err !== 1'b0)      begin n_bad++; $display("FAIL wr_bus_err: got %b want 0", bus.bus_err); end
  endtask

  task automatic test_reset_mid();
    int hits;
    hits = 0;
    cyc();
    bus.mod_rdy = 16'h0000; bus.mod = 8'd1; bus.we = 1'b0; bus.eff_addr = 32'h300; bus.req = 1'b1;
    cyc();
    @(negedge clk);
    n_cmp++; if (bus.stall !== 1'b1)        begin n_bad++; $display("FAIL rm_wait_stall: got %b want 1", bus.stall); end
    cyc();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.stall !== 1'b0)        begin n_bad++; $display("FAIL rm_stall: got %b want 0", bus.stall); end
    n_cmp++; if (bus.cpu_data !== 32'h0)    begin n_bad++; $display("FAIL rm_cpu_data: got %h want 0", bus.cpu_data); end
    n_cmp++; if (bus.err_flag !== 1'b0)     begin n_bad++; $display("FAIL rm_err_flag: got %b want 0", bus.err_flag); end
    n_cmp++; if (bus.err_addr !== 32'h0)    begin n_bad++; $display("FAIL rm_err_addr: got %h want 0", bus.err_addr); end
    bus.req = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      @(negedge clk);
      if (bus.ack === 1'b1 || bus.bus_err === 1'b1) hits++;
    end
    n_cmp++; if (hits !== 0)                begin n_bad++; $display("FAIL rm_no_resp: got %0d want 0", hits); end
    cyc();
    bus.mod_rdy = 16'h0004; bus.mod = 8'd2; bus.req = 1'b1;
    cyc();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ack !== 1'b1)          begin n_bad++; $display("FAIL rm_new_ack: got %b want 1", bus.ack); end
    n_cmp++; if (bus.cpu_data !== 32'h12345678) begin n_bad++; $display("FAIL rm_new_data: got %h want 12345678", bus.cpu_data); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.mod      = 8'd0;
    bus.eff_addr = 32'h0;
    bus.mod_rdy  = 16'h0;
    bus.clr_err  = 1'b0;
    bus.mod_data = '0;
    bus.mod_data[32 +: 32]  = 32'hCAFEF00D;
    bus.mod_data[64 +: 32]  = 32'h12345678;
    bus.mod_data[96 +: 32]  = 32'hAAAA5555;
    bus.mod_data[128 +: 32] = 32'h11112222;
    bus.mod_data[160 +: 32] = 32'h55555555;

    test_reset();
    test_read_ready();
    test_read_wait();
    test_timeout();
    test_bad_mod();
    test_write();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
